// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared states and constants for the uart_tx_port transmitter
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [4:0] DEF_DATA_ADDR = 5'h1E;
  localparam logic [4:0] DEF_STAT_ADDR = 5'h1F;

  localparam int ST_SHIFTING  = 0;
  localparam int ST_HOLD_FULL = 1;
  localparam int ST_OVERRUN   = 2;

endpackage

// File: rtl/uart_tx_port_baud_gen.sv
// rtl/uart_tx_port_baud_gen.sv - bit-period divider; tick marks the last clock of each bit
module baud_gen #(
  parameter int BAUD_DIV = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run & (cnt == LAST);

  // Held at zero while stopped so the first bit after start is a full period
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - bus-mapped serial transmitter with one-byte holding register
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_port
  import uart_tx_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int OP_W = 3,
  parameter int BAUD_DIV = 16,
  parameter logic [WORD_W-OP_W-1:0] DATA_ADDR = DEF_DATA_ADDR,
  parameter logic [WORD_W-OP_W-1:0] STAT_ADDR = DEF_STAT_ADDR
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WORD_W-OP_W-1:0] address,
  input  logic                   CS,
  input  logic                   R_NW,
  inout  wire  [WORD_W-1:0]      sysbus,
  output logic                   txd,
  output logic                   tx_busy
);

  tx_state_t         state, state_n;
  logic [WORD_W-1:0] hold, shift, status;
  logic [2:0]        bit_cnt;
  logic              hold_full, overrun, wr_q, rd_q;
  logic              wr_stb, rd_stb, wr_acc, tick, load, txd_n, shifting;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  assign wr_stb   = CS & ~R_NW & (address == DATA_ADDR);
  assign rd_stb   = CS & R_NW & (address == STAT_ADDR);
  assign wr_acc   = wr_stb & ~wr_q;
  assign shifting = (state != IDLE);
  assign tx_busy  = shifting | hold_full;

  always_comb begin
    status               = '0;
    status[ST_SHIFTING]  = shifting;
    status[ST_HOLD_FULL] = hold_full;
    status[ST_OVERRUN]   = overrun;
  end

  assign sysbus = rd_stb ? status : {WORD_W{1'bz}};

  baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clock(clock),
    .reset(reset),
    .run  (shifting),
    .tick (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      txd   <= 1'b1;
    end else begin
      state <= state_n;
      txd   <= txd_n;
    end
  end

  // txd_n is the line level for the state being entered, keeping txd registered
  always_comb begin
    state_n = state;
    txd_n   = txd;
    load    = 1'b0;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (hold_full) begin
          state_n = START;
          load    = 1'b1;
          txd_n   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          txd_n   = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            txd_n   = par;
`else
            state_n = STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            txd_n = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          txd_n   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (hold_full) begin
            state_n = START;
            load    = 1'b1;
            txd_n   = 1'b0;
          end else begin
            state_n = IDLE;
            txd_n   = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      wr_q <= wr_stb;
      rd_q <= rd_stb;
      if (load) begin
        shift   <= hold;
        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        par     <= ^hold[7:0];
`endif
      end else if (state == DATA && tick) begin
        shift   <= shift >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
      // A write landing on the transfer edge refills the slot just vacated
      if (wr_acc && (!hold_full || load)) begin
        hold      <= sysbus;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (wr_acc && hold_full && !load) begin
        overrun <= 1'b1;
      end else if (rd_stb && !rd_q) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - scoreboard bench for uart_tx_port with BAUD_DIV=4
module tb_uart_tx_port;

  localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FLEN = NB * BAUD;
  localparam logic [4:0] DADDR = 5'h1E;
  localparam logic [4:0] SADDR = 5'h1F;

  typedef struct {
    logic [7:0] data;
    int         exp_start;
    bit         b2b;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] address = '0;
  logic       CS = 1'b0;
  logic       R_NW = 1'b0;
  logic [7:0] drv = '0;
  logic       drv_en = 1'b0;
  wire  [7:0] sysbus;
  logic       txd, tx_busy;

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, last_end = 0, frames_done = 0;
  bit   in_frame = 1'b0;
  exp_t sb[$];

  assign sysbus = drv_en ? drv : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (sysbus[i]);
  end

  uart_tx_port #(.BAUD_DIV(BAUD)) dut (
    .clock  (clock),
    .reset  (reset),
    .address(address),
    .CS     (CS),
    .R_NW   (R_NW),
    .sysbus (sysbus),
    .txd    (txd),
    .tx_busy(tx_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic [7:0] d);
    logic [31:0] f;
    f = '0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]  = ^d;
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  task automatic bus_write(input logic [7:0] d, input int ncyc, input bit push, input bit b2b);
    exp_t e;
    @(negedge clock);
    address = DADDR; R_NW = 1'b0; CS = 1'b1; drv = d; drv_en = 1'b1;
    @(posedge clock);
    #1;
    if (push) begin
      e.data = d;
      e.exp_start = b2b ? -1 : cyc + 1;
      e.b2b = b2b;
      sb.push_back(e);
    end
    repeat (ncyc - 1) @(posedge clock);
    @(negedge clock);
    CS = 1'b0; drv_en = 1'b0;
  endtask

  task automatic rd_status(output logic [7:0] v);
    @(negedge clock);
    address = SADDR; R_NW = 1'b1; CS = 1'b1;
    #1 v = sysbus;
    @(posedge clock);
    @(negedge clock);
    CS = 1'b0; R_NW = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || in_frame || tx_busy) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check(tag, {31'b0, (n < 3000)}, 32'd1);
  endtask

  // Frame monitor: pops the expected byte at each start bit and checks every sample
  initial begin : monitor
    exp_t        e;
    logic [31:0] expf, obsf;
    bit          ok, ab;
    forever begin
      @(negedge clock);
      if (!reset && txd === 1'b0) begin
        if (sb.size() == 0) begin
          check("stray_frame", {31'b0, txd}, 32'd1);
        end else begin
          e = sb.pop_front();
          in_frame = 1'b1;
          if (e.exp_start >= 0) check("start_edge", cyc, e.exp_start);
          if (e.b2b) check("b2b_gap", cyc, last_end + 1);
          expf = frame_of(e.data);
          obsf = '0;
          ok = 1'b1;
          ab = 1'b0;
          for (int b = 0; b < NB && !ab; b++) begin
            for (int c = 0; c < BAUD; c++) begin
              if (b != 0 || c != 0) @(negedge clock);
              if (reset) begin
                ab = 1'b1;
                break;
              end
              if (c == 0) obsf[b] = txd;
              else if (txd !== obsf[b]) ok = 1'b0;
            end
          end
          if (!ab) begin
            check("frame_bits", obsf, expf);
            check("bit_hold", {31'b0, ok}, 32'd1);
            frames_done++;
            last_end = cyc;
          end
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] st;
    int f0;
    bit idle_ok;

    repeat (3) @(negedge clock);
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    reset = 1'b0;

    idle_ok = 1'b1;
    repeat (50) begin
      @(negedge clock);
      if (txd !== 1'b1 || tx_busy !== 1'b0 || sysbus !== 8'hFF) idle_ok = 1'b0;
    end
    check("idle_50", {31'b0, idle_ok}, 32'd1);
    rd_status(st);
    check("st_reset", {24'b0, st}, 32'h00);
    @(negedge clock);
    check("bus_released", {24'b0, sysbus}, 32'hFF);

    bus_write(8'hA5, 1, 1'b1, 1'b0);
    check("busy_after_wr", {31'b0, tx_busy}, 32'd1);
    repeat (FLEN) @(negedge clock);
    check("busy_last_stop", {31'b0, tx_busy}, 32'd1);
    @(negedge clock);
    check("busy_drop", {31'b0, tx_busy}, 32'd0);
    wait_idle("drain_a5");

    bus_write(8'h3C, 1, 1'b1, 1'b0);
    repeat (6) @(negedge clock);
    bus_write(8'hFF, 1, 1'b1, 1'b1);
    bus_write(8'h11, 1, 1'b0, 1'b0);
    rd_status(st);
    check("st_overrun", {24'b0, st}, 32'h07);
    rd_status(st);
    check("st_cleared", {24'b0, st}, 32'h03);
    wait_idle("drain_b2b");
    rd_status(st);
    check("st_after_b2b", {24'b0, st}, 32'h00);

    f0 = frames_done;
    bus_write(8'h55, 3, 1'b1, 1'b0);
    wait_idle("drain_55");
    check("one_frame_55", frames_done - f0, 32'd1);
    rd_status(st);
    check("st_no_overrun", {24'b0, st}, 32'h00);

`ifdef UART_TX_PARITY_EN
    bus_write(8'h07, 1, 1'b1, 1'b0);
    wait_idle("drain_07");
`endif

    bus_write(8'h96, 1, 1'b1, 1'b0);
    repeat (18) @(posedge clock);
    #2;
    check("pre_reset_txd", {31'b0, txd}, 32'd0);
    reset = 1'b1;
    #1;
    check("reset_txd", {31'b0, txd}, 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rd_status(st);
    check("st_post_reset", {24'b0, st}, 32'h00);
    f0 = frames_done;
    idle_ok = 1'b1;
    repeat (60) begin
      @(negedge clock);
      if (txd !== 1'b1 || tx_busy !== 1'b0) idle_ok = 1'b0;
    end
    check("post_reset_idle", {31'b0, idle_ok}, 32'd1);
    check("no_stray", frames_done - f0, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
